// File: rtl/c3lib_ckg_ctrl_pkg.sv
// Shared definitions for the clock-gater controller: the per-domain state
// encoding and the helper that sizes the settle/idle/stagger counters.
package c3lib_ckg_ctrl_pkg;

   // Per-domain state. The encoding is fixed at 3 bits so that the debug
   // state bus has a stable layout.
   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PEND   = 3'd1,
      S_SETTLE = 3'd2,
      S_ON     = 3'd3,
      S_IDLE   = 3'd4
   } ckg_state_e;

   // The same encodings as plain constants. Legacy consumers and the FSM
   // compare against these.
   localparam logic [2:0] ST_OFF    = S_OFF;
   localparam logic [2:0] ST_PEND   = S_PEND;
   localparam logic [2:0] ST_SETTLE = S_SETTLE;
   localparam logic [2:0] ST_ON     = S_ON;
   localparam logic [2:0] ST_IDLE   = S_IDLE;

   // Returns the counter width needed to hold the largest reload value.
   // One width is shared by all three counters.
   function automatic int ckg_cnt_w(input int settle_cyc, input int idle_cyc,
                                    input int stagger_cyc);
      int m;
      m = settle_cyc;
      if (idle_cyc > m) m = idle_cyc;
      if (stagger_cyc > m) m = stagger_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/c3lib_ckg_ctrl_fsm.sv
// State machine for one clock domain.
// It handles the req/ack handshake, holds ack off while the gated clock
// settles, and applies idle hysteresis before the clock is gated off.
//
// Handshake (4-phase, level):
//   - The requester raises req_o and waits for ack_o to rise.
//   - The requester then drops req_o and waits for ack_o to fall.
//   - ack_o rises only after the gated clock has run SETTLE_CYC cycles.
//   - ack_o falls together with en_o, once req has stayed low for IDLE_CYC cycles.
//   - req may change at any time. The state machine below defines the result.
module c3lib_ckg_ctrl_fsm
   import c3lib_ckg_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int IDLE_CYC   = 8,
   parameter int CW         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_i,
   input  logic       grant_i,
   output logic       pend_o,
   output logic       settle_o,
   output logic       en_o,
   output logic       ack_o,
   output logic [2:0] state_o
);

   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] IDLE_LD   = CW'(IDLE_CYC - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_q, en_d;
   logic          ack_q, ack_d;

   // Next-state logic. en and ack are computed here from the next state,
   // so that every output is driven from a register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      case (state_q)
         ST_OFF: begin
            if (req_i) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (!req_i) begin
               state_d = ST_OFF;
            end else if (grant_i) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               if (req_i) begin
                  state_d = ST_ON;
                  ack_d   = 1'b1;
               end else begin
                  // Abandoned before ack: idle out with ack held low.
                  state_d = ST_IDLE;
                  cnt_d   = IDLE_LD;
                  ack_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_ON: begin
            if (!req_i) begin
               state_d = ST_IDLE;
               cnt_d   = IDLE_LD;
            end
         end
         ST_IDLE: begin
            if (req_i) begin
               // The clock never stopped, so no re-settle is needed.
               state_d = ST_ON;
               ack_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_OFF;
               ack_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
            ack_d   = 1'b0;
         end
      endcase
      en_d = (state_d == ST_SETTLE) || (state_d == ST_ON) || (state_d == ST_IDLE);
   end

   // State, counter and output registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
      end
   end

   assign pend_o   = (state_q == ST_PEND);
   assign settle_o = (state_q == ST_SETTLE);
   assign en_o     = en_q;
   assign ack_o    = ack_q;
   assign state_o  = state_q;

endmodule

// File: rtl/c3lib_ckg_ctrl_seq.sv
// Controller for a bank of clock gaters.
// This top level holds one FSM per domain, a round-robin turn-on arbiter
// with a global stagger counter (to limit di/dt), and the test-enable OR
// that drives the gater clk_en pins.
module c3lib_ckg_ctrl_seq
   import c3lib_ckg_ctrl_pkg::*;
#(
   parameter int NUM_CKG     = 4,
   parameter int SETTLE_CYC  = 4,
   parameter int IDLE_CYC    = 8,
   parameter int STAGGER_CYC = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tst_en,
   input  logic [NUM_CKG-1:0]   req,
   output logic [NUM_CKG-1:0]   ack,
   output logic [NUM_CKG-1:0]   ckg_en,
   output logic                 busy,
   output logic [3*NUM_CKG-1:0] fsm_state_o
);

   localparam int CW = ckg_cnt_w(SETTLE_CYC, IDLE_CYC, STAGGER_CYC);
   localparam int PW = (NUM_CKG > 1) ? $clog2(NUM_CKG) : 1;

   logic [NUM_CKG-1:0] pend, settle, fsm_en, fsm_ack, grant;
   logic [CW-1:0]      stg_cnt_q, stg_cnt_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic               found;
   int                 idx;

   // One FSM per domain.
   for (genvar g = 0; g < NUM_CKG; g++) begin : g_fsm
      c3lib_ckg_ctrl_fsm #(
         .SETTLE_CYC(SETTLE_CYC),
         .IDLE_CYC  (IDLE_CYC),
         .CW        (CW)
      ) u_fsm (
         .clk     (clk),
         .rst_n   (rst_n),
         .req_i   (req[g]),
         .grant_i (grant[g]),
         .pend_o  (pend[g]),
         .settle_o(settle[g]),
         .en_o    (fsm_en[g]),
         .ack_o   (fsm_ack[g]),
         .state_o (fsm_state_o[3*g +: 3])
      );
   end

   // Stagger arbiter. While the stagger counter is non-zero it only counts
   // down. When it is zero, it grants the first PEND domain that still
   // requests, searching round-robin from the pointer. A domain dropping req
   // while in PEND is not eligible, so it never consumes a slot.
   always_comb begin
      grant     = '0;
      ptr_d     = ptr_q;
      stg_cnt_d = stg_cnt_q;
      found     = 1'b0;
      idx       = 0;
      if (stg_cnt_q != '0) begin
         stg_cnt_d = stg_cnt_q - CW'(1);
      end else begin
         for (int k = 0; k < NUM_CKG; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CKG) idx = idx - NUM_CKG;
            if (!found && pend[idx] && req[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               ptr_d      = (idx == NUM_CKG - 1) ? '0 : PW'(idx + 1);
               stg_cnt_d  = CW'(STAGGER_CYC - 1);
            end
         end
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_cnt_q <= '0;
         ptr_q     <= '0;
      end else begin
         stg_cnt_q <= stg_cnt_d;
         ptr_q     <= ptr_d;
      end
   end

   // tst_en mirrors the gater test-enable. It is the only combinational
   // path to an output and it does not touch the FSMs.
   assign ckg_en = fsm_en | {NUM_CKG{tst_en}};
   assign ack    = fsm_ack;
   assign busy   = |(pend | settle);

endmodule

// File: tb/tb_c3lib_ckg_ctrl_seq.sv
// Directed bench for c3lib_ckg_ctrl_seq with the default parameters
// (4 domains, settle 4, idle 8, stagger 3). Edges are counted from the
// first edge after reset is released. Inputs are changed 1 ns after an
// edge and outputs are sampled there too.
module tb_c3lib_ckg_ctrl_seq;
   import c3lib_ckg_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tst_en;
   logic [3:0]  req;
   logic [3:0]  ack;
   logic [3:0]  ckg_en;
   logic        busy;
   logic [11:0] fsm_state_o;

   int n_checks = 0;
   int n_errors = 0;
   int ecnt     = 0;

   c3lib_ckg_ctrl_seq #(
      .NUM_CKG(4), .SETTLE_CYC(4), .IDLE_CYC(8), .STAGGER_CYC(3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tst_en     (tst_en),
      .req        (req),
      .ack        (ack),
      .ckg_en     (ckg_en),
      .busy       (busy),
      .fsm_state_o(fsm_state_o)
   );

   // Clock generator.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic to_edge(input int n);
      while (ecnt < n) tick();
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      tst_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      ecnt  = 0;
   endtask

   initial begin
      rst_n  = 1'b0;
      tst_en = 1'b0;
      req    = '0;

      // Reset state.
      do_reset();
      check("rst_en", ckg_en, 4'h0);
      check("rst_ack", ack, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", fsm_state_o, 12'h000);

      // 1. Single wake/sleep on domain 0.
      to_edge(9);  req = 4'h1;
      to_edge(10);
      check("t1_pend_en", ckg_en, 4'h0);
      check("t1_pend_busy", busy, 1'b1);
      check("t1_pend_state", fsm_state_o[2:0], ST_PEND);
      to_edge(11);
      check("t1_en11", ckg_en, 4'h1);
      check("t1_ack11", ack, 4'h0);
      to_edge(14);
      check("t1_ack14", ack, 4'h0);
      to_edge(15);
      check("t1_ack15", ack, 4'h1);
      check("t1_busy15", busy, 1'b0);
      to_edge(19); req = 4'h0;
      to_edge(27);
      check("t1_en27", ckg_en, 4'h1);
      check("t1_ack27", ack, 4'h1);
      check("t1_state27", fsm_state_o[2:0], ST_IDLE);
      to_edge(28);
      check("t1_en28", ckg_en, 4'h0);
      check("t1_ack28", ack, 4'h0);
      check("t1_state28", fsm_state_o[2:0], ST_OFF);

      // 2. Simultaneous wake: staggered grants in round-robin order.
      do_reset();
      to_edge(9);  req = 4'hF;
      to_edge(11); check("t2_en11", ckg_en, 4'h1);
      to_edge(13); check("t2_en13", ckg_en, 4'h1);
      to_edge(14); check("t2_en14", ckg_en, 4'h3);
      to_edge(15); check("t2_ack15", ack, 4'h1);
      to_edge(17); check("t2_en17", ckg_en, 4'h7);
      to_edge(18); check("t2_ack18", ack, 4'h3);
      to_edge(20); check("t2_en20", ckg_en, 4'hF);
      to_edge(21); check("t2_ack21", ack, 4'h7);
      to_edge(23);
      check("t2_ack23", ack, 4'h7);
      check("t2_busy23", busy, 1'b1);
      to_edge(24);
      check("t2_ack24", ack, 4'hF);
      check("t2_busy24", busy, 1'b0);

      // 3. Re-request while in IDLE.
      do_reset();
      to_edge(9);  req = 4'h1;
      to_edge(19); req = 4'h0;
      to_edge(23);
      check("t3_state23", fsm_state_o[2:0], ST_IDLE);
      req = 4'h1;
      to_edge(24);
      check("t3_state24", fsm_state_o[2:0], ST_ON);
      check("t3_en24", ckg_en, 4'h1);
      check("t3_ack24", ack, 4'h1);
      to_edge(32);
      check("t3_en32", ckg_en, 4'h1);
      check("t3_ack32", ack, 4'h1);

      // 4. Domain 3 withdraws while in PEND.
      do_reset();
      to_edge(9);  req = 4'hF;
      to_edge(14); req = 4'h7;
      to_edge(15); check("t4_state3", fsm_state_o[11:9], ST_OFF);
      to_edge(17); check("t4_en17", ckg_en, 4'h7);
      to_edge(20);
      check("t4_en20", ckg_en, 4'h7);
      to_edge(21);
      check("t4_ack21", ack, 4'h7);
      check("t4_busy21", busy, 1'b0);
      to_edge(24); req = 4'hF;
      to_edge(25);
      check("t4_en25", ckg_en, 4'h7);
      check("t4_state25", fsm_state_o[11:9], ST_PEND);
      to_edge(26);
      check("t4_en26", ckg_en, 4'hF);

      // 5. Test mode forces ckg_en, even in reset.
      do_reset();
      rst_n = 1'b0; tst_en = 1'b1;
      tick();
      check("t5_en", ckg_en, 4'hF);
      check("t5_ack", ack, 4'h0);
      check("t5_busy", busy, 1'b0);
      tst_en = 1'b0;
      #1;
      check("t5_en_drop", ckg_en, 4'h0);
      rst_n = 1'b1;

      // 6. Reset in the middle of operation, then a fresh request.
      do_reset();
      to_edge(9);  req = 4'hF;
      to_edge(30);
      check("t6_ack30", ack, 4'hF);
      to_edge(39); rst_n = 1'b0; req = 4'h0;
      to_edge(40);
      check("t6_en40", ckg_en, 4'h0);
      check("t6_ack40", ack, 4'h0);
      check("t6_busy40", busy, 1'b0);
      check("t6_state40", fsm_state_o, 12'h000);
      rst_n = 1'b1; req = 4'h8;
      to_edge(41);
      check("t6_en41", ckg_en, 4'h0);
      check("t6_busy41", busy, 1'b1);
      to_edge(42);
      check("t6_en42", ckg_en, 4'h8);
      to_edge(46);
      check("t6_ack46", ack, 4'h8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
